// File: rtl/forward_north_south_if.sv
// Bundles the vertical forwarding stage's source-FIFO, forward-buffer and local-buffer signals.
// The stage itself takes the slave view; whatever drives it takes the master view.
interface forward_north_south_if #(
   parameter int PACKET_WIDTH = 21,
   parameter int DY_LSB       = 12
);
   logic [PACKET_WIDTH-1:0] din_routing;
   logic                    empty_routing;
   logic                    ren_out_routing;
   logic [PACKET_WIDTH-1:0] din_turn;
   logic                    empty_turn;
   logic                    ren_out_turn;
   logic                    ren_in_routing;
   logic [PACKET_WIDTH-1:0] dout_routing;
   logic                    routing_buffer_empty;
   logic                    ren_in_local;
   logic [DY_LSB-1:0]       dout_local;
   logic                    local_buffer_empty;

   modport slave (
      input  din_routing, empty_routing, din_turn, empty_turn, ren_in_routing, ren_in_local,
      output ren_out_routing, ren_out_turn, dout_routing, routing_buffer_empty,
             dout_local, local_buffer_empty
   );

   modport master (
      output din_routing, empty_routing, din_turn, empty_turn, ren_in_routing, ren_in_local,
      input  ren_out_routing, ren_out_turn, dout_routing, routing_buffer_empty,
             dout_local, local_buffer_empty
   );
endinterface

// File: rtl/forward_north_south.sv
// Vertical forwarding stage of the RANC router: round-robin arbitration between the vertical link
// and the east/west turn FIFO, with dy stepping toward zero or delivery to the local core.

module forward_north_south_fifo #(
   parameter int WIDTH = 21,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wen,
   input  logic [WIDTH-1:0] din,
   input  logic             ren,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_write;
   logic             do_read;

   // Full blocks writes even when a read frees a slot in the same cycle.
   assign empty    = (count == '0);
   assign full     = (count == (PTR_W + 1)'(DEPTH));
   assign do_write = wen && !full;
   assign do_read  = ren && !empty;
   assign dout     = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (do_read)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_write, do_read})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr] <= din;
   end
endmodule

module forward_north_south #(
   parameter int PACKET_WIDTH = 21,
   parameter int DY_MSB       = 20,
   parameter int DY_LSB       = 12,
   parameter int BUFFER_DEPTH = 4,
   parameter bit NORTH        = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   forward_north_south_if.slave bus
);
   localparam int DY_W = DY_MSB - DY_LSB + 1;

   typedef enum logic {PRIO_ROUTING, PRIO_TURN} prio_t;

   prio_t                   prio;
   prio_t                   prio_next;
   logic                    routing_local;
   logic                    turn_local;
   logic                    routing_eligible;
   logic                    turn_eligible;
   logic                    grant_routing;
   logic                    grant_turn;
   logic                    sel_local;
   logic [PACKET_WIDTH-1:0] sel_pkt;
   logic [DY_W-1:0]         sel_dy;
   logic [DY_W-1:0]         stepped_dy;
   logic [PACKET_WIDTH-1:0] fwd_pkt;
   logic                    fwd_wen;
   logic                    loc_wen;
   logic                    fwd_full;
   logic                    fwd_empty;
   logic                    loc_full;
   logic                    loc_empty;
   logic [PACKET_WIDTH-1:0] fwd_dout;
   logic [DY_LSB-1:0]       loc_dout;

   // Each source only checks its own destination, so one blocked head never stalls the other.
   assign routing_local    = (bus.din_routing[DY_MSB:DY_LSB] == '0);
   assign turn_local       = (bus.din_turn[DY_MSB:DY_LSB] == '0);
   assign routing_eligible = rst && !bus.empty_routing && (routing_local ? !loc_full : !fwd_full);
   assign turn_eligible    = rst && !bus.empty_turn    && (turn_local    ? !loc_full : !fwd_full);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prio <= PRIO_ROUTING;
      else      prio <= prio_next;
   end

   // After any grant, priority passes to the source that was not served.
   always_comb begin
      grant_routing = 1'b0;
      grant_turn    = 1'b0;
      prio_next     = prio;
      if (routing_eligible && (!turn_eligible || prio == PRIO_ROUTING)) begin
         grant_routing = 1'b1;
         prio_next     = PRIO_TURN;
      end else if (turn_eligible) begin
         grant_turn = 1'b1;
         prio_next  = PRIO_ROUTING;
      end
   end

   assign bus.ren_out_routing = grant_routing;
   assign bus.ren_out_turn    = grant_turn;

   assign sel_pkt    = grant_turn ? bus.din_turn : bus.din_routing;
   assign sel_local  = grant_turn ? turn_local : routing_local;
   assign sel_dy     = sel_pkt[DY_MSB:DY_LSB];
   assign stepped_dy = NORTH ? (sel_dy - 1'b1) : (sel_dy + 1'b1);
   assign fwd_pkt    = {stepped_dy, sel_pkt[DY_LSB-1:0]};
   assign fwd_wen    = (grant_routing || grant_turn) && !sel_local;
   assign loc_wen    = (grant_routing || grant_turn) && sel_local;

   forward_north_south_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(BUFFER_DEPTH)) fwd_fifo (
      .clk   (clk),
      .rst   (rst),
      .wen   (fwd_wen),
      .din   (fwd_pkt),
      .ren   (bus.ren_in_routing),
      .dout  (fwd_dout),
      .empty (fwd_empty),
      .full  (fwd_full)
   );

   forward_north_south_fifo #(.WIDTH(DY_LSB), .DEPTH(BUFFER_DEPTH)) loc_fifo (
      .clk   (clk),
      .rst   (rst),
      .wen   (loc_wen),
      .din   (sel_pkt[DY_LSB-1:0]),
      .ren   (bus.ren_in_local),
      .dout  (loc_dout),
      .empty (loc_empty),
      .full  (loc_full)
   );

   assign bus.dout_routing         = fwd_dout;
   assign bus.routing_buffer_empty = fwd_empty;
   assign bus.dout_local           = loc_dout;
   assign bus.local_buffer_empty   = loc_empty;
endmodule

// File: tb/tb_forward_north_south.sv
// Scoreboard bench for forward_north_south: a packet-level model predicts grants and the
// contents of both output buffers; a separate monitor compares buffer heads as they appear.
module tb_forward_north_south;
   localparam int PW     = 21;
   localparam int DY_MSB = 20;
   localparam int DY_LSB = 12;
   localparam int DEPTH  = 4;
   localparam int DYW    = DY_MSB - DY_LSB + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   forward_north_south_if #(.PACKET_WIDTH(PW), .DY_LSB(DY_LSB)) nif();
   forward_north_south_if #(.PACKET_WIDTH(PW), .DY_LSB(DY_LSB)) sif();

   forward_north_south #(.PACKET_WIDTH(PW), .DY_MSB(DY_MSB), .DY_LSB(DY_LSB),
                         .BUFFER_DEPTH(DEPTH), .NORTH(1'b1)) dut_north (
      .clk (clk),
      .rst (rst),
      .bus (nif)
   );

   forward_north_south #(.PACKET_WIDTH(PW), .DY_MSB(DY_MSB), .DY_LSB(DY_LSB),
                         .BUFFER_DEPTH(DEPTH), .NORTH(1'b0)) dut_south (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   int errors = 0;
   int checks = 0;

   logic [PW-1:0]     q_routing[$];
   logic [PW-1:0]     q_turn[$];
   logic [PW-1:0]     exp_fwd[$];
   logic [DY_LSB-1:0] exp_loc[$];
   bit                prio_turn = 1'b0;
   int                avail_pct  = 100;
   int                read_pct_r = 0;
   int                read_pct_l = 0;
   logic [PW-1:0]     pkt_a;

   function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Northbound stepping: dy moves one hop toward zero by subtracting one, payload untouched.
   function automatic logic [PW-1:0] north_step(logic [PW-1:0] p);
      logic [DYW-1:0] dy;
      dy = p[DY_MSB:DY_LSB] - DYW'(1);
      return {dy, p[DY_LSB-1:0]};
   endfunction

   function automatic logic [PW-1:0] make_pkt(logic [DYW-1:0] dy, logic [DY_LSB-1:0] payload);
      return {dy, payload};
   endfunction

   function automatic logic [PW-1:0] rand_pkt();
      logic [DYW-1:0] dy;
      case ($urandom_range(3))
         0:       dy = '0;
         1:       dy = DYW'(1);
         2:       dy = DYW'(2);
         default: dy = DYW'($urandom);
      endcase
      return {dy, DY_LSB'($urandom)};
   endfunction

   // One clock of stimulus: present source heads, predict the grant, then record its effect.
   task automatic applyStimulus();
      bit r_avail, t_avail, r_loc, t_loc, r_ok, t_ok, g_r, g_t;
      @(negedge clk);
      r_avail = (q_routing.size() > 0) && ($urandom_range(99) < avail_pct);
      t_avail = (q_turn.size() > 0) && ($urandom_range(99) < avail_pct);
      nif.empty_routing  = !r_avail;
      nif.empty_turn     = !t_avail;
      nif.din_routing    = (q_routing.size() > 0) ? q_routing[0] : PW'($urandom);
      nif.din_turn       = (q_turn.size() > 0) ? q_turn[0] : PW'($urandom);
      nif.ren_in_routing = ($urandom_range(99) < read_pct_r);
      nif.ren_in_local   = ($urandom_range(99) < read_pct_l);
      #1;
      r_loc = (nif.din_routing[DY_MSB:DY_LSB] == '0);
      t_loc = (nif.din_turn[DY_MSB:DY_LSB] == '0);
      r_ok  = r_avail && (r_loc ? (exp_loc.size() < DEPTH) : (exp_fwd.size() < DEPTH));
      t_ok  = t_avail && (t_loc ? (exp_loc.size() < DEPTH) : (exp_fwd.size() < DEPTH));
      g_r   = r_ok && (!t_ok || !prio_turn);
      g_t   = t_ok && !g_r;
      if (!rst) begin
         g_r = 1'b0;
         g_t = 1'b0;
      end
      checkOutput("ren_out_routing", nif.ren_out_routing, g_r);
      checkOutput("ren_out_turn", nif.ren_out_turn, g_t);
      @(posedge clk);
      if (g_r) begin
         if (r_loc) exp_loc.push_back(q_routing[0][DY_LSB-1:0]);
         else       exp_fwd.push_back(north_step(q_routing[0]));
         void'(q_routing.pop_front());
         prio_turn = 1'b1;
      end
      if (g_t) begin
         if (t_loc) exp_loc.push_back(q_turn[0][DY_LSB-1:0]);
         else       exp_fwd.push_back(north_step(q_turn[0]));
         void'(q_turn.pop_front());
         prio_turn = 1'b0;
      end
   endtask

   task automatic drain();
      avail_pct  = 100;
      read_pct_r = 100;
      read_pct_l = 100;
      for (int i = 0; i < 200 && (q_routing.size() + q_turn.size() + exp_fwd.size() + exp_loc.size()) > 0; i++)
         applyStimulus();
      checkOutput("drain_fwd_left", exp_fwd.size(), 0);
      checkOutput("drain_loc_left", exp_loc.size(), 0);
      checkOutput("drain_src_left", q_routing.size() + q_turn.size(), 0);
      read_pct_r = 0;
      read_pct_l = 0;
   endtask

   // Monitor: whenever the DUT is out of reset, buffer flags and heads must match the scoreboard.
   always begin
      @(negedge clk);
      #2;
      if (rst) begin
         checkOutput("routing_buffer_empty", nif.routing_buffer_empty, exp_fwd.size() == 0);
         if (exp_fwd.size() > 0) begin
            checkOutput("dout_routing", nif.dout_routing, exp_fwd[0]);
            if (nif.ren_in_routing) void'(exp_fwd.pop_front());
         end
         checkOutput("local_buffer_empty", nif.local_buffer_empty, exp_loc.size() == 0);
         if (exp_loc.size() > 0) begin
            checkOutput("dout_local", nif.dout_local, exp_loc[0]);
            if (nif.ren_in_local) void'(exp_loc.pop_front());
         end
      end
   end

   initial begin
      nif.din_routing = '0; nif.empty_routing = 1'b1; nif.din_turn = '0; nif.empty_turn = 1'b1;
      nif.ren_in_routing = 1'b0; nif.ren_in_local = 1'b0;
      sif.din_routing = '0; sif.empty_routing = 1'b1; sif.din_turn = '0; sif.empty_turn = 1'b1;
      sif.ren_in_routing = 1'b0; sif.ren_in_local = 1'b0;

      // Reset held with both sources offering packets: nothing may be granted.
      q_routing.push_back(make_pkt(DYW'(1), 12'h111));
      q_turn.push_back(make_pkt(DYW'(0), 12'h222));
      repeat (2) applyStimulus();
      #2;
      checkOutput("reset_routing_empty", nif.routing_buffer_empty, 1);
      checkOutput("reset_local_empty", nif.local_buffer_empty, 1);
      checkOutput("reset_dout_routing", nif.dout_routing, 0);
      checkOutput("reset_dout_local", nif.dout_local, 0);
      #1 rst = 1'b1;
      repeat (3) applyStimulus();
      drain();

      // Turn source, dy=0: lands in the local buffer one cycle later.
      q_turn.push_back(make_pkt(DYW'(0), 12'hABC));
      applyStimulus();
      #3;
      checkOutput("t2_local_empty", nif.local_buffer_empty, 0);
      checkOutput("t2_dout_local", nif.dout_local, 12'hABC);
      drain();

      // Routing source, dy=3: forwarded with dy=2.
      q_routing.push_back(make_pkt(DYW'(3), 12'h123));
      applyStimulus();
      #3;
      checkOutput("t3_dout_routing", nif.dout_routing, {9'd2, 12'h123});
      drain();

      // Southbound instance steps dy upward; dy=0 still goes local.
      @(negedge clk);
      sif.din_routing = {9'h1FE, 12'h5A5}; sif.empty_routing = 1'b0;
      #1 checkOutput("south_grant_fwd", sif.ren_out_routing, 1);
      @(negedge clk);
      sif.din_routing = {9'h000, 12'h0F0};
      #1 checkOutput("south_grant_loc", sif.ren_out_routing, 1);
      checkOutput("south_dy_step", sif.dout_routing, {9'h1FF, 12'h5A5});
      @(negedge clk);
      sif.empty_routing = 1'b1;
      #1;
      checkOutput("south_fwd_empty", sif.routing_buffer_empty, 0);
      checkOutput("south_dout_local", sif.dout_local, 12'h0F0);

      // Both sources busy toward the forward buffer: alternate until it fills.
      for (int i = 0; i < 3; i++) begin
         q_routing.push_back(make_pkt(DYW'(1), DY_LSB'($urandom)));
         q_turn.push_back(make_pkt(DYW'(1), DY_LSB'($urandom)));
      end
      repeat (7) applyStimulus();
      checkOutput("t4_fwd_full_count", exp_fwd.size(), DEPTH);
      drain();

      // Forward buffer full: local-bound turn packets still pass; one read frees routing.
      for (int i = 0; i < 5; i++) q_routing.push_back(make_pkt(DYW'(1), DY_LSB'($urandom)));
      repeat (4) applyStimulus();
      q_turn.push_back(make_pkt(DYW'(0), 12'h00A));
      q_turn.push_back(make_pkt(DYW'(0), 12'h00B));
      repeat (2) applyStimulus();
      read_pct_r = 100;
      applyStimulus();
      read_pct_r = 0;
      applyStimulus();
      checkOutput("t5_routing_left", q_routing.size(), 0);
      drain();

      // Mid-cycle reset with packets buffered discards them at once.
      for (int i = 0; i < 3; i++) q_routing.push_back(make_pkt(DYW'(2), DY_LSB'(i + 1)));
      repeat (3) applyStimulus();
      #2 rst = 1'b0;
      #1;
      checkOutput("t6_routing_empty", nif.routing_buffer_empty, 1);
      checkOutput("t6_local_empty", nif.local_buffer_empty, 1);
      q_routing.delete(); q_turn.delete(); exp_fwd.delete(); exp_loc.delete();
      prio_turn = 1'b0;
      pkt_a = make_pkt(DYW'(5), 12'h777);
      q_routing.push_back(pkt_a);
      q_turn.push_back(make_pkt(DYW'(4), 12'h888));
      applyStimulus();
      #3 rst = 1'b1;
      applyStimulus();
      #3 checkOutput("t6_first_after_reset", nif.dout_routing, {9'd4, 12'h777});
      drain();

      // Randomised traffic.
      avail_pct  = 70;
      read_pct_r = 50;
      read_pct_l = 50;
      for (int i = 0; i < 400; i++) begin
         if (q_routing.size() < 6 && $urandom_range(1)) q_routing.push_back(rand_pkt());
         if (q_turn.size() < 6 && $urandom_range(1)) q_turn.push_back(rand_pkt());
         if ((i % 50) == 0) begin
            read_pct_r = $urandom_range(100);
            read_pct_l = $urandom_range(100);
         end
         applyStimulus();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
